// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Boot loader that sits between a UART receiver and the RAM write mux.
//   It watches the byte stream for MAGIC. After the magic it reads a header
//   (4-byte base word address, then a 4-byte word count, both MSB first).
//   It then streams DATA_BYTES-wide words to the RAM write port. A trailing
//   8-bit checksum byte is verified last. A good load pulses done_o and
//   holds system_reset_no low for RST_PULSE_CYCLES cycles.
//
// Ports
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   rx_valid_i       one-cycle strobe, rx_data_i valid
//   rx_data_i        received byte
//   wr_en_o          RAM write strobe (one cycle per word)
//   wr_addr_o        RAM word address
//   wr_data_o        RAM write data, first received byte in the MSBs
//   wr_strb_o        byte enables, all ones with wr_en_o
//   prog_mode_o      high while a session is being parsed
//   done_o           one-cycle pulse on a successful load
//   err_o            sticky error (timeout / bad checksum), cleared on magic
//   system_reset_no  active-low system reset request
module uart_prog_loader #(
  parameter int unsigned  DATA_BYTES       = 4,
  parameter int unsigned  ADDR_WIDTH       = 17,
  parameter logic [127:0] MAGIC            = "TEKNOFEST",
  parameter int unsigned  MAGIC_LEN        = 9,
  parameter int unsigned  TIMEOUT_CYCLES   = 1000000,
  parameter int unsigned  RST_PULSE_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rx_valid_i,
  input  logic [7:0]              rx_data_i,
  output logic                    wr_en_o,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [8*DATA_BYTES-1:0] wr_data_o,
  output logic [DATA_BYTES-1:0]   wr_strb_o,
  output logic                    prog_mode_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    system_reset_no
);

  localparam int unsigned DW    = 8 * DATA_BYTES;
  localparam int unsigned ML    = 8 * MAGIC_LEN;
  localparam int unsigned BC_W  = $clog2(DATA_BYTES) + 1;
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RST_W = $clog2(RST_PULSE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_ADDR, S_HDR_LEN, S_DATA, S_CSUM, S_RST
  } state_e;

  state_e                  state_q;
  logic [ML-1:0]           magic_q;
  logic [31:0]             hdr_q;
  logic [1:0]              hdr_cnt_q;
  logic [DW-1:0]           word_q;
  logic [BC_W-1:0]         byte_cnt_q;
  logic [31:0]             words_left_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              sum_q;
  logic [GAP_W-1:0]        gap_q;
  logic [RST_W-1:0]        rst_cnt_q;

  logic                    wr_en_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DW-1:0]           wr_data_q;
  logic [DATA_BYTES-1:0]   wr_strb_q;
  logic                    prog_mode_q;
  logic                    done_q;
  logic                    err_q;
  logic                    sys_rst_nq;

  // Shift values including the byte on rx_data_i this cycle; newest byte
  // lands in the LSBs so that MSB-first streams assemble naturally.
  logic [ML-1:0] magic_d;
  logic [31:0]   hdr_d;
  logic [DW-1:0] word_d;

  assign magic_d = (magic_q << 8) | ML'(rx_data_i);
  assign hdr_d   = {hdr_q[23:0], rx_data_i};
  assign word_d  = (word_q << 8) | DW'(rx_data_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      magic_q      <= '0;
      hdr_q        <= '0;
      hdr_cnt_q    <= '0;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      words_left_q <= '0;
      addr_q       <= '0;
      sum_q        <= '0;
      gap_q        <= '0;
      rst_cnt_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_strb_q    <= '0;
      prog_mode_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      sys_rst_nq   <= 1'b1;
    end else begin
      wr_en_q   <= 1'b0;
      wr_strb_q <= '0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_valid_i) begin
            if (magic_d == MAGIC[ML-1:0]) begin
              // Clearing here gives the next IDLE visit an empty history.
              magic_q     <= '0;
              err_q       <= 1'b0;
              prog_mode_q <= 1'b1;
              hdr_cnt_q   <= '0;
              sum_q       <= '0;
              gap_q       <= '0;
              state_q     <= S_HDR_ADDR;
            end else begin
              magic_q <= magic_d;
            end
          end
        end
        S_RST: begin
          // Incoming bytes are deliberately ignored while reset is held.
          if (rst_cnt_q == RST_W'(RST_PULSE_CYCLES - 1)) begin
            sys_rst_nq <= 1'b1;
            rst_cnt_q  <= '0;
            state_q    <= S_IDLE;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        default: begin
          if (rx_valid_i) begin
            gap_q <= '0;
            sum_q <= sum_q + rx_data_i;
            case (state_q)
              S_HDR_ADDR: begin
                hdr_q     <= hdr_d;
                hdr_cnt_q <= hdr_cnt_q + 1'b1;
                if (hdr_cnt_q == 2'd3) begin
                  addr_q  <= hdr_d[ADDR_WIDTH-1:0];
                  state_q <= S_HDR_LEN;
                end
              end
              S_HDR_LEN: begin
                hdr_q     <= hdr_d;
                hdr_cnt_q <= hdr_cnt_q + 1'b1;
                if (hdr_cnt_q == 2'd3) begin
                  words_left_q <= hdr_d;
                  word_q       <= '0;
                  byte_cnt_q   <= '0;
                  state_q      <= (hdr_d == 32'd0) ? S_CSUM : S_DATA;
                end
              end
              S_DATA: begin
                if (byte_cnt_q == BC_W'(DATA_BYTES - 1)) begin
                  wr_en_q      <= 1'b1;
                  wr_strb_q    <= '1;
                  wr_data_q    <= word_d;
                  wr_addr_q    <= addr_q;
                  addr_q       <= addr_q + 1'b1;
                  word_q       <= '0;
                  byte_cnt_q   <= '0;
                  words_left_q <= words_left_q - 1'b1;
                  if (words_left_q == 32'd1) state_q <= S_CSUM;
                end else begin
                  word_q     <= word_d;
                  byte_cnt_q <= byte_cnt_q + 1'b1;
                end
              end
              S_CSUM: begin
                prog_mode_q <= 1'b0;
                if (rx_data_i == sum_q) begin
                  done_q     <= 1'b1;
                  sys_rst_nq <= 1'b0;
                  rst_cnt_q  <= '0;
                  state_q    <= S_RST;
                end else begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
                end
              end
              default: ;
            endcase
          end else if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
            // Gap reaches TIMEOUT_CYCLES this cycle: abandon the session and
            // drop any partially assembled word.
            err_q       <= 1'b1;
            prog_mode_q <= 1'b0;
            gap_q       <= '0;
            word_q      <= '0;
            byte_cnt_q  <= '0;
            hdr_cnt_q   <= '0;
            state_q     <= S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign wr_en_o         = wr_en_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_data_o       = wr_data_q;
  assign wr_strb_o       = wr_strb_q;
  assign prog_mode_o     = prog_mode_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign system_reset_no = sys_rst_nq;

endmodule
